// File: rtl/key_event_encoder.sv
// key_event_encoder
// Turns the debounced, active-low key levels into discrete key events
// (press, release, long-press and optionally auto-repeat). Events are held in
// a per-key pending slot. They are then queued in a small FIFO and presented
// on a valid/ready stream, one event per handshake.
//
// Build option: define KEY_REPEAT_EN to enable auto-repeat events (type 11).
// These are issued every REPEAT_CYC cycles after a long-press while the key
// stays held. Without the macro the LONG state only waits for release.
//
// Parameters
//   KEY_N      number of key lines (event key index is 2 bits wide)
//   LONG_CYC   cycles from press event to long-press event (>= 2)
//   REPEAT_CYC cycles between repeat events after long-press (>= 2)
//   FIFO_DEPTH event queue entries (power of two, >= 2)
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   Key_In     debounced key levels, 0 = pressed
//   Evt_Valid  head-of-queue event available
//   Evt_Ready  consumer accepts the head event this cycle
//   Evt_Key    key index of the head event
//   Evt_Type   00 press, 01 release, 10 long, 11 repeat
//   Evt_Ovf    sticky flag: an event was overwritten before it was queued

module key_event_encoder #(
  parameter int unsigned KEY_N      = 4,
  parameter int unsigned LONG_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [KEY_N-1:0] Key_In,
  output logic             Evt_Valid,
  input  logic             Evt_Ready,
  output logic [1:0]       Evt_Key,
  output logic [1:0]       Evt_Type,
  output logic             Evt_Ovf
);

  localparam int unsigned CNT_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [1:0]       EV_REPEAT = 2'b11;
`endif
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1,
    S_LONG = 2'd2
  } key_state_t;

  typedef struct packed {
    logic [1:0] key;
    logic [1:0] kind;
  } evt_t;

  // ---------------------------------------------------------------------------
  // Input sampling and edge detection
  // ---------------------------------------------------------------------------
  logic [KEY_N-1:0] k_r;
  logic [KEY_N-1:0] k_d;
  // Set by reset; a key's bit clears once that key has been seen released.
  // This keeps a key held through reset from producing a press.
  logic [KEY_N-1:0] mask;
  logic [KEY_N-1:0] press_e;
  logic [KEY_N-1:0] rel_e;

  always_ff @(posedge CLK) begin
    if (RST) begin
      k_r  <= '1;
      k_d  <= '1;
      mask <= '1;
    end else begin
      k_r  <= Key_In;
      k_d  <= k_r;
      mask <= mask & ~Key_In;
    end
  end

  assign press_e = k_d & ~k_r & ~mask;
  assign rel_e   = ~k_d & k_r;

  // ---------------------------------------------------------------------------
  // Per-key press / long / repeat FSM
  // ---------------------------------------------------------------------------
  logic [KEY_N-1:0]      ev_v;
  logic [KEY_N-1:0][1:0] ev_k;

  for (genvar gi = 0; gi < KEY_N; gi++) begin : g_key
    key_state_t       st_q;
    key_state_t       st_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             raise;
    logic [1:0]       kind;

    // Saturating increment so an oversized hold can never wrap the counter
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // State and counter register
    always_ff @(posedge CLK) begin
      if (RST) begin
        st_q  <= S_IDLE;
        cnt_q <= '0;
      end else begin
        st_q  <= st_n;
        cnt_q <= cnt_n;
      end
    end

    // Next state and counter; release outranks long/repeat in the same cycle
    always_comb begin
      st_n  = st_q;
      cnt_n = cnt_q;
      case (st_q)
        S_IDLE: begin
          if (press_e[gi]) begin
            st_n  = S_HELD;
            cnt_n = '0;
          end
        end
        S_HELD: begin
          if (rel_e[gi]) begin
            st_n  = S_IDLE;
            cnt_n = '0;
          end else if (cnt_q == LONG_LAST) begin
            st_n  = S_LONG;
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        S_LONG: begin
          if (rel_e[gi]) begin
            st_n  = S_IDLE;
            cnt_n = '0;
          end
`ifdef KEY_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            cnt_n = '0;
          end else begin
            cnt_n = cnt_inc;
          end
`endif
        end
        default: begin
          st_n  = S_IDLE;
          cnt_n = '0;
        end
      endcase
    end

    // Event raised this cycle for this key
    always_comb begin
      raise = 1'b0;
      kind  = EV_PRESS;
      case (st_q)
        S_IDLE: begin
          if (press_e[gi]) begin
            raise = 1'b1;
            kind  = EV_PRESS;
          end
        end
        S_HELD: begin
          if (rel_e[gi]) begin
            raise = 1'b1;
            kind  = EV_RELEASE;
          end else if (cnt_q == LONG_LAST) begin
            raise = 1'b1;
            kind  = EV_LONG;
          end
        end
        S_LONG: begin
          if (rel_e[gi]) begin
            raise = 1'b1;
            kind  = EV_RELEASE;
          end
`ifdef KEY_REPEAT_EN
          else if (cnt_q == REP_LAST) begin
            raise = 1'b1;
            kind  = EV_REPEAT;
          end
`endif
        end
        default: begin
          raise = 1'b0;
          kind  = EV_PRESS;
        end
      endcase
    end

    assign ev_v[gi] = raise;
    assign ev_k[gi] = kind;
  end

  // ---------------------------------------------------------------------------
  // Pending slots and lowest-index-first arbiter
  // ---------------------------------------------------------------------------
  logic [KEY_N-1:0]      pend_v;
  logic [KEY_N-1:0][1:0] pend_t;
  logic [KEY_N-1:0]      grant;
  logic                  push;
  evt_t                  push_evt;
  logic                  pop;
  logic                  full;
  logic                  can_push;
  logic [CW-1:0]         f_cnt_q;

  assign pop      = Evt_Valid & Evt_Ready;
  assign full     = (f_cnt_q == FULL_CNT);
  // A full queue still accepts a push in a cycle that also pops
  assign can_push = ~full | pop;

  always_comb begin
    grant    = '0;
    push     = 1'b0;
    push_evt = '0;
    for (int i = 0; i < KEY_N; i++) begin
      if (!push && pend_v[i] && can_push) begin
        grant[i]      = 1'b1;
        push          = 1'b1;
        push_evt.key  = 2'(i);
        push_evt.kind = pend_t[i];
      end
    end
  end

  // A new event replaces an unqueued one; that loss is recorded in Evt_Ovf
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_v  <= '0;
      pend_t  <= '0;
      Evt_Ovf <= 1'b0;
    end else begin
      for (int i = 0; i < KEY_N; i++) begin
        if (ev_v[i]) begin
          pend_v[i] <= 1'b1;
          pend_t[i] <= ev_k[i];
        end else if (grant[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
      Evt_Ovf <= Evt_Ovf | (|(ev_v & pend_v & ~grant));
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO with registered head outputs
  // ---------------------------------------------------------------------------
  evt_t          mem_q [FIFO_DEPTH];
  evt_t          mem_n [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] wr_n;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rd_n;
  logic [CW-1:0] f_cnt_n;
  evt_t          head_n;

  always_comb begin
    mem_n   = mem_q;
    wr_n    = wr_q;
    rd_n    = rd_q;
    if (push) begin
      mem_n[wr_q] = push_evt;
      wr_n        = wr_q + AW'(1);
    end
    if (pop) begin
      rd_n = rd_q + AW'(1);
    end
    f_cnt_n = f_cnt_q + CW'(push) - CW'(pop);
    head_n  = mem_n[rd_n];
  end

  // Head registered from the next-cycle view so it holds while not popped
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q      <= '0;
      rd_q      <= '0;
      f_cnt_q   <= '0;
      Evt_Valid <= 1'b0;
      Evt_Key   <= 2'b00;
      Evt_Type  <= 2'b00;
    end else begin
      mem_q     <= mem_n;
      wr_q      <= wr_n;
      rd_q      <= rd_n;
      f_cnt_q   <= f_cnt_n;
      Evt_Valid <= (f_cnt_n != '0);
      Evt_Key   <= head_n.key;
      Evt_Type  <= head_n.kind;
    end
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with LONG_CYC=8, REPEAT_CYC=4, FIFO_DEPTH=4.
// A negedge monitor logs every delivered event with its cycle number. The main
// sequence compares that log and the live outputs against hand-computed values.
module tb_key_event_encoder;

  localparam int unsigned KEY_N      = 4;
  localparam int unsigned LONG_CYC   = 8;
  localparam int unsigned REPEAT_CYC = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic             CLK;
  logic             RST;
  logic [KEY_N-1:0] Key_In;
  logic             Evt_Valid;
  logic             Evt_Ready;
  logic [1:0]       Evt_Key;
  logic [1:0]       Evt_Type;
  logic             Evt_Ovf;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] key;
    logic [1:0] kind;
    int         cyc;
  } rec_t;

  rec_t got[$];

  key_event_encoder #(
    .KEY_N      (KEY_N),
    .LONG_CYC   (LONG_CYC),
    .REPEAT_CYC (REPEAT_CYC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Key_In    (Key_In),
    .Evt_Valid (Evt_Valid),
    .Evt_Ready (Evt_Ready),
    .Evt_Key   (Evt_Key),
    .Evt_Type  (Evt_Type),
    .Evt_Ovf   (Evt_Ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Log each handshake; the pop itself happens on the following rising edge
  always @(negedge CLK) begin
    if (!RST && Evt_Valid && Evt_Ready) begin
      rec_t r;
      r.key  = Evt_Key;
      r.kind = Evt_Type;
      r.cyc  = cyc;
      got.push_back(r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int idx, input logic [1:0] k, input logic [1:0] t);
    logic [31:0] obs;
    if (idx < got.size()) obs = {28'd0, got[idx].key, got[idx].kind};
    else                  obs = 32'hFFFF_FFFF;
    chk(tag, obs, {28'd0, k, t});
  endtask

  task automatic chk_gap(input string tag, input int a, input int b, input int exp);
    logic [31:0] obs;
    if (a < got.size() && b < got.size()) obs = 32'(got[b].cyc - got[a].cyc);
    else                                  obs = 32'hFFFF_FFFF;
    chk(tag, obs, 32'(exp));
  endtask

  task automatic chk_head(input string tag, input logic [1:0] k, input logic [1:0] t);
    chk(tag, {29'd0, Evt_Valid, Evt_Key, Evt_Type}, {29'd0, 1'b1, k, t});
  endtask

  initial begin
    RST       = 1'b1;
    Key_In    = 4'hF;
    Evt_Ready = 1'b0;
    tick(3);
    chk("reset valid", 32'(Evt_Valid), 32'd0);
    chk("reset key",   32'(Evt_Key),   32'd0);
    chk("reset type",  32'(Evt_Type),  32'd0);
    chk("reset ovf",   32'(Evt_Ovf),   32'd0);
    RST = 1'b0;
    tick(3);

    // Key 2 held 20 cycles: latency, long after 8, repeats every 4, release
    Evt_Ready = 1'b1;
    got.delete();
    Key_In = 4'b1011;
    tick(1);
    chk("lat e0 valid", 32'(Evt_Valid), 32'd0);
    tick(1);
    chk("lat e1 valid", 32'(Evt_Valid), 32'd0);
    tick(1);
    chk_head("lat e2 head", 2'd2, 2'b00);
    tick(17);
    Key_In = 4'hF;
    tick(20);
`ifdef KEY_REPEAT_EN
    chk("hold count", 32'(got.size()), 32'd5);
    chk_evt("hold press",   0, 2'd2, 2'b00);
    chk_evt("hold long",    1, 2'd2, 2'b10);
    chk_evt("hold rep1",    2, 2'd2, 2'b11);
    chk_evt("hold rep2",    3, 2'd2, 2'b11);
    chk_evt("hold release", 4, 2'd2, 2'b01);
    chk_gap("gap long",     0, 1, 8);
    chk_gap("gap rep1",     1, 2, 4);
    chk_gap("gap rep2",     2, 3, 4);
    chk_gap("gap release",  0, 4, 20);
`else
    chk("hold count", 32'(got.size()), 32'd3);
    chk_evt("hold press",   0, 2'd2, 2'b00);
    chk_evt("hold long",    1, 2'd2, 2'b10);
    chk_evt("hold release", 2, 2'd2, 2'b01);
    chk_gap("gap long",     0, 1, 8);
    chk_gap("gap release",  0, 2, 20);
`endif

    // Keys 0 and 3 pressed together
    got.delete();
    Key_In = 4'b0110;
    tick(5);
    Key_In = 4'hF;
    tick(10);
    chk("dual count", 32'(got.size()), 32'd4);
    chk_evt("dual p0", 0, 2'd0, 2'b00);
    chk_evt("dual p3", 1, 2'd3, 2'b00);
    chk_evt("dual r0", 2, 2'd0, 2'b01);
    chk_evt("dual r3", 3, 2'd3, 2'b01);
    chk_gap("dual gap", 0, 1, 1);

    // Short press on key 0: no long event
    got.delete();
    Key_In = 4'b1110;
    tick(3);
    Key_In = 4'hF;
    tick(10);
    chk("short count", 32'(got.size()), 32'd2);
    chk_evt("short press",   0, 2'd0, 2'b00);
    chk_evt("short release", 1, 2'd0, 2'b01);
    chk_gap("short gap", 0, 1, 3);

    // Back-pressure: 4 queued, 2 held pending, all delivered in order
    Evt_Ready = 1'b0;
    got.delete();
    Key_In = 4'b1110; tick(2); Key_In = 4'hF; tick(3);
    Key_In = 4'b1101; tick(2); Key_In = 4'hF; tick(3);
    chk_head("bp full head", 2'd0, 2'b00);
    Key_In = 4'b0011;
    tick(4);
    chk_head("bp blocked head", 2'd0, 2'b00);
    chk("bp nothing taken", 32'(got.size()), 32'd0);
    chk("bp ovf before", 32'(Evt_Ovf), 32'd0);
    Evt_Ready = 1'b1;
    tick(2);
    Key_In = 4'hF;
    tick(20);
    chk("bp count", 32'(got.size()), 32'd8);
    chk_evt("bp 0", 0, 2'd0, 2'b00);
    chk_evt("bp 1", 1, 2'd0, 2'b01);
    chk_evt("bp 2", 2, 2'd1, 2'b00);
    chk_evt("bp 3", 3, 2'd1, 2'b01);
    chk_evt("bp 4", 4, 2'd2, 2'b00);
    chk_evt("bp 5", 5, 2'd3, 2'b00);
    chk_evt("bp 6", 6, 2'd2, 2'b01);
    chk_evt("bp 7", 7, 2'd3, 2'b01);
    chk("bp ovf after", 32'(Evt_Ovf), 32'd0);

    // Pending overwrite while the queue is full sets the sticky overflow
    Evt_Ready = 1'b0;
    got.delete();
    Key_In = 4'b1110; tick(2); Key_In = 4'hF; tick(3);
    Key_In = 4'b1110; tick(2); Key_In = 4'hF; tick(3);
    chk("ovf pre", 32'(Evt_Ovf), 32'd0);
    Key_In = 4'b1101; tick(2); Key_In = 4'hF; tick(3);
    chk("ovf set", 32'(Evt_Ovf), 32'd1);
    chk_head("ovf head", 2'd0, 2'b00);
    Evt_Ready = 1'b1;
    tick(10);
    chk("ovf count", 32'(got.size()), 32'd5);
    chk_evt("ovf 0", 0, 2'd0, 2'b00);
    chk_evt("ovf 3", 3, 2'd0, 2'b01);
    chk_evt("ovf last", 4, 2'd1, 2'b01);
    tick(5);
    chk("ovf sticky", 32'(Evt_Ovf), 32'd1);

    // Reset with key 3 held and an event queued
    Evt_Ready = 1'b0;
    got.delete();
    Key_In = 4'b0111;
    tick(4);
    chk_head("rst pre head", 2'd3, 2'b00);
    RST = 1'b1;
    tick(1);
    chk("rst valid", 32'(Evt_Valid), 32'd0);
    chk("rst ovf",   32'(Evt_Ovf),   32'd0);
    chk("rst key",   32'(Evt_Key),   32'd0);
    chk("rst type",  32'(Evt_Type),  32'd0);
    RST = 1'b0;
    Evt_Ready = 1'b1;
    tick(15);
    chk("rst held quiet", 32'(got.size()), 32'd0);
    chk("rst held valid", 32'(Evt_Valid), 32'd0);
    Key_In = 4'hF;
    tick(5);
    chk("rst release quiet", 32'(got.size()), 32'd0);
    Key_In = 4'b0111;
    tick(3);
    Key_In = 4'hF;
    tick(8);
    chk("rst repress count", 32'(got.size()), 32'd2);
    chk_evt("rst repress", 0, 2'd3, 2'b00);
    chk_evt("rst rerelease", 1, 2'd3, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Consumer of the four debounced key lines from the key-interface stage. Converts level changes on each key into discrete events: press, release, long-press and optional auto-repeat. Events are queued in a small FIFO and presented on a valid/ready stream to the control logic (menu FSM, counters, display). One event is delivered per handshake, tagged with key index and event type.

## Interface
- KEY_N, 4, number of key lines (key index width fixed at 2 bits)
- LONG_CYC, 50_000_000, held cycles from press event to long-press event (≥2)
- REPEAT_CYC, 10_000_000, cycles between repeat events after long-press (≥2)
- FIFO_DEPTH, 4, event queue entries (power of two, ≥2)
- CLK  in  1  system clock, all logic rising-edge
- RST  in  1  synchronous, active-high reset
- Key_In  in  4  debounced key levels, active-low (0 = pressed)
- Evt_Valid  out  1  head-of-queue event available
- Evt_Ready  in  1  consumer accepts event this cycle
- Evt_Key  out  2  key index of head event (0..3, matches Key_In bit)
- Evt_Type  out  2  00 press, 01 release, 10 long, 11 repeat
- Evt_Ovf  out  1  sticky: at least one event was dropped

## Operation
- Stage 1: Key_In registered into k_r; previous value kept in k_d. Reset loads both with 4'hF (all released).
- Per-key FSM: IDLE (released), HELD (pressed, timing to long), LONG (long issued).
  - IDLE -> HELD on k_d=1, k_r=0: raise press event, clear counter.
  - HELD: counter increments each cycle; at count = LONG_CYC-1 raise long event, clear counter, -> LONG.
  - LONG: with KEY_REPEAT_EN, counter increments; at REPEAT_CYC-1 raise repeat event, clear counter, stay.
  - HELD or LONG -> IDLE on k_d=0, k_r=1: raise release event. Release takes priority over long/repeat in the same cycle.
- Raised events set a per-key pending register {type}. A new event for a key with pending still set overwrites it and sets Evt_Ovf.
- Arbiter: each cycle, lowest-index pending key is written to the FIFO and its pending cleared. FIFO full and no pop in that cycle: pending held (not dropped); it retries next cycle.
- FIFO: Evt_Valid = not empty; Evt_Key/Evt_Type show head entry, stable while Evt_Valid=1 and Evt_Ready=0. Pop when Evt_Valid & Evt_Ready. Push and pop in the same cycle when full are both performed.
- Evt_Ovf cleared only by RST.
- Counter width = $clog2(max(LONG_CYC, REPEAT_CYC)); counters saturate, never wrap.

## Timing
- Reset (RST=1 at an edge): all FSMs IDLE, counters 0, pending clear, FIFO empty, Evt_Valid=0, Evt_Key=0, Evt_Type=0, Evt_Ovf=0. Reset mid-event discards queued and pending events; held keys produce a fresh press only after release then press.
- Latency: Key_In edge sampled at edge E0 -> pending at E1 -> FIFO write at E2 -> Evt_Valid=1 after E2 (FIFO empty, no competing keys).
- Long event raised LONG_CYC cycles after the press event is raised; repeat events every REPEAT_CYC cycles thereafter.
- Simultaneous press on several keys: events enter FIFO on consecutive cycles, ascending key index.
- Evt_Ready ignored while Evt_Valid=0.

## Configuration
- KEY_REPEAT_EN defined: LONG state generates repeat events (type 11) every REPEAT_CYC cycles while held.
- Undefined: LONG state only waits for release; type 11 never produced; repeat counter logic removed.

## Test plan
- LONG_CYC=8, REPEAT_CYC=4, Evt_Ready=1: press key 2 for 20 cycles -> press(2,00), long(2,10) 8 cycles later, repeats (2,11) every 4 cycles (with KEY_REPEAT_EN), release(2,01).
- Press keys 0 and 3 in the same cycle -> press(0) then press(3) on consecutive valid cycles.
- Evt_Ready=0, generate 6 events with FIFO_DEPTH=4 -> 4 queued, remainder held pending, Evt_Valid stays 1 with head unchanged; raise Ready -> all 6 delivered in order, Evt_Ovf=0.
- Ready=0, FIFO full, key 1 press then release while pending blocked -> pending overwritten with release, Evt_Ovf=1 and stays 1 until RST.
- Press key 0 for 3 cycles (< LONG_CYC) -> press and release only, no long event.
- Assert RST while key held and FIFO non-empty -> Evt_Valid=0, Evt_Ovf=0 next cycle; no event until key released and pressed again.
